counter_gidc_p: RTL and testbench

Parametrised up/down counter generalising the fixed 3-bit gradual increment/decrement counter. Supports runtime-selectable wrap-up, wrap-down, ping-pong and hold modes, programmable bounds, a compile-time step, synchronous load and a registered wrap/turn event. It is a standalone sequencing primitive for the daily/revision block set, for use as an address sweeper or PWM ramp source.

---
 rtl/counter_gidc_p_pkg.sv | 15 +
 rtl/counter_gidc_p_if.sv | 30 +++
 rtl/counter_gidc_p_dwell_timer.sv | 38 +++
 rtl/counter_gidc_p.sv | 170 +++++++++++++++++
 tb/tb_counter_gidc_p.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/counter_gidc_p_pkg.sv
// counter_gidc_pkg: mode encodings and direction constants shared by the
// counter_gidc_p block, its bus interface and its bench.
package counter_gidc_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_gidc_p_if.sv
// counter_gidc_p_if: control/status bundle of the gradual up/down counter.
// master = the sequencer driving the counter, slave = the counter itself.
interface counter_gidc_p_if
  import counter_gidc_pkg::*;
#(
  parameter int WIDTH = 3
);
  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             evt;
  logic             at_hi;
  logic             at_lo;
  logic             cfg_err;

  modport master (
    output en, mode, lo, hi, load, load_val,
    input  count, dir, evt, at_hi, at_lo, cfg_err
  );

  modport slave (
    input  en, mode, lo, hi, load, load_val,
    output count, dir, evt, at_hi, at_lo, cfg_err
  );
endinterface

// File: rtl/counter_gidc_p_dwell_timer.sv
// gidc_dwell_timer: DWELL-cycle down-counter used to hold the ping-pong
// counter at an endpoint. start loads DWELL, tick decrements, clr empties.
// done is high whenever no dwell cycles remain.
module gidc_dwell_timer #(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic start,
  input  logic tick,
  output logic done
);
  localparam int CW = (DWELL < 1) ? 1 : $clog2(DWELL + 1);

  logic [CW-1:0] cnt_d, cnt_q;

  // Next remaining-dwell value: clear beats start beats tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (start)
      cnt_d = CW'(DWELL);
    else if (tick && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // Remaining-dwell register.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/counter_gidc_p.sv
// counter_gidc_p: parametrised up/down counter with wrap-up, wrap-down,
// ping-pong and hold modes, programmable inclusive bounds, compile-time STEP,
// synchronous load and a registered wrap/turn event.
// Optional macro GIDC_DWELL_EN adds a DWELL-cycle pause at ping-pong endpoints.
module counter_gidc_p
  import counter_gidc_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int STEP  = 1,
  parameter int DWELL = 2
) (
  input logic              clk,
  input logic              rst,
  counter_gidc_p_if.slave  bus
);
  localparam int EW = WIDTH + 1;

  logic [WIDTH-1:0] count_d, count_q;
  logic             dir_d, dir_q;
  logic             evt_d, evt_q;

  // Bounds arithmetic is done one bit wider so sums never wrap silently.
  logic [EW-1:0] cnt_e, lo_e, hi_e, step_e;
  logic [EW-1:0] up_sum, dn_diff, lo_step, hi_less;
  logic          cfg_err_w, at_hi_w, at_lo_w, oor;
  logic          dwell_done;

  assign cnt_e   = {1'b0, count_q};
  assign lo_e    = {1'b0, bus.lo};
  assign hi_e    = {1'b0, bus.hi};
  assign step_e  = EW'(STEP);
  assign up_sum  = cnt_e + step_e;
  assign dn_diff = cnt_e - step_e;
  assign lo_step = lo_e + step_e;
  assign hi_less = hi_e - step_e;

  assign cfg_err_w = (bus.lo > bus.hi);
  assign at_hi_w   = (count_q == bus.hi);
  assign at_lo_w   = (count_q == bus.lo);
  assign oor       = (count_q < bus.lo) || (count_q > bus.hi);

`ifdef GIDC_DWELL_EN
  mode_t mode_prev_q;
  logic  dwell_start, dwell_tick, dwell_clr;

  assign dwell_clr = bus.load || (bus.mode != mode_prev_q);

  gidc_dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clr   (dwell_clr),
    .start (dwell_start),
    .tick  (dwell_tick),
    .done  (dwell_done)
  );

  // Last-seen mode, so a mode change can abandon a pending dwell.
  always_ff @(posedge clk) begin
    if (rst)
      mode_prev_q <= MODE_HOLD;
    else
      mode_prev_q <= bus.mode;
  end
`else
  wire dwell_unused = (DWELL != 0);
  assign dwell_done = 1'b1;
`endif

  // Next count/dir/evt: load beats an enabled step; cfg_err and hold freeze.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    evt_d   = 1'b0;
`ifdef GIDC_DWELL_EN
    dwell_start = 1'b0;
    dwell_tick  = 1'b0;
`endif
    if (bus.load) begin
      count_d = bus.load_val;
    end else if (bus.en && !cfg_err_w && bus.mode != MODE_HOLD) begin
      if (oor) begin
        // Recovery step back into the window never flags an event.
        if (bus.mode == MODE_DOWN) begin
          count_d = bus.hi;
          dir_d   = DIR_DOWN;
        end else begin
          count_d = bus.lo;
          dir_d   = DIR_UP;
        end
      end else begin
        case (bus.mode)
          MODE_UP: begin
            dir_d = DIR_UP;
            if (up_sum > hi_e) begin
              count_d = bus.lo;
              evt_d   = 1'b1;
            end else begin
              count_d = up_sum[WIDTH-1:0];
            end
          end
          MODE_DOWN: begin
            dir_d = DIR_DOWN;
            if (cnt_e < lo_step) begin
              count_d = bus.hi;
              evt_d   = 1'b1;
            end else begin
              count_d = dn_diff[WIDTH-1:0];
            end
          end
          MODE_PINGPONG: begin
            if (dir_q == DIR_UP) begin
              if (at_hi_w) begin
`ifdef GIDC_DWELL_EN
                if (!dwell_done) dwell_tick = 1'b1; else
`endif
                begin
                  dir_d   = DIR_DOWN;
                  evt_d   = 1'b1;
                  count_d = (hi_e < lo_step) ? bus.lo : hi_less[WIDTH-1:0];
                end
              end else begin
                count_d = (up_sum > hi_e) ? bus.hi : up_sum[WIDTH-1:0];
              end
            end else begin
              if (at_lo_w) begin
`ifdef GIDC_DWELL_EN
                if (!dwell_done) dwell_tick = 1'b1; else
`endif
                begin
                  dir_d   = DIR_UP;
                  evt_d   = 1'b1;
                  count_d = (lo_step > hi_e) ? bus.hi : lo_step[WIDTH-1:0];
                end
              end else begin
                count_d = (cnt_e < lo_step) ? bus.lo : dn_diff[WIDTH-1:0];
              end
            end
`ifdef GIDC_DWELL_EN
            // Arming the dwell whenever a real move lands on the endpoint
            // the counter is now heading for.
            if (!dwell_tick && count_d == (dir_d ? bus.hi : bus.lo))
              dwell_start = 1'b1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Count, direction and event registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      dir_q   <= DIR_UP;
      evt_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      evt_q   <= evt_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.dir     = dir_q;
  assign bus.evt     = evt_q;
  assign bus.at_hi   = at_hi_w;
  assign bus.at_lo   = at_lo_w;
  assign bus.cfg_err = cfg_err_w;
endmodule

// File: tb/tb_counter_gidc_p.sv
// Directed bench for counter_gidc_p: four instances with different WIDTH/STEP
// share clk/rst; expected values are hand-computed tables.
module tb_counter_gidc_p;
  import counter_gidc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  counter_gidc_p_if #(.WIDTH(3)) if1 ();
  counter_gidc_p_if #(.WIDTH(3)) if2 ();
  counter_gidc_p_if #(.WIDTH(3)) if3 ();
  counter_gidc_p_if #(.WIDTH(4)) if4 ();

  counter_gidc_p #(.WIDTH(3), .STEP(1), .DWELL(2)) u1 (.clk(clk), .rst(rst), .bus(if1));
  counter_gidc_p #(.WIDTH(3), .STEP(2), .DWELL(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
  counter_gidc_p #(.WIDTH(3), .STEP(3), .DWELL(2)) u3 (.clk(clk), .rst(rst), .bus(if3));
  counter_gidc_p #(.WIDTH(4), .STEP(1), .DWELL(2)) u4 (.clk(clk), .rst(rst), .bus(if4));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq_a [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int seq_b [4]  = '{2, 4, 2, 4};
    int evt_b [4]  = '{0, 0, 1, 0};
    int seq_c [7]  = '{3, 6, 7, 4, 1, 0, 3};
    int evt_c [7]  = '{0, 0, 0, 1, 0, 0, 1};
    int seq_d [3]  = '{4, 1, 7};
    int seq_w [5]  = '{6, 7, 7, 7, 6};

    if1.en = 0; if1.load = 0; if1.load_val = 0; if1.mode = MODE_HOLD; if1.lo = 0; if1.hi = 7;
    if2.en = 0; if2.load = 0; if2.load_val = 0; if2.mode = MODE_HOLD; if2.lo = 0; if2.hi = 7;
    if3.en = 0; if3.load = 0; if3.load_val = 0; if3.mode = MODE_HOLD; if3.lo = 0; if3.hi = 7;
    if4.en = 0; if4.load = 0; if4.load_val = 0; if4.mode = MODE_HOLD; if4.lo = 0; if4.hi = 15;

    // Reset state
    rst = 1'b1;
    tick();
    chk("rst_count", int'(if1.count), 0);
    chk("rst_dir",   int'(if1.dir),   1);
    chk("rst_evt",   int'(if1.evt),   0);
    chk("rst_count_w4", int'(if4.count), 0);
    rst = 1'b0;

`ifndef GIDC_DWELL_EN
    // Ping-pong STEP=1 over 0..7, period 14
    if1.mode = MODE_PINGPONG; if1.en = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("pp1_count[%0d]", i), int'(if1.count), seq_a[i]);
      chk($sformatf("pp1_evt[%0d]", i),   int'(if1.evt), (i == 7 || i == 14) ? 1 : 0);
      if (i == 6) chk("pp1_at_hi", int'(if1.at_hi), 1);
    end
    if1.en = 0;
`else
    // Dwell: 7 held three cycles before turning to 6
    if1.mode = MODE_PINGPONG; if1.load = 1; if1.load_val = 5;
    tick();
    chk("dw_load", int'(if1.count), 5);
    if1.load = 0; if1.en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("dw_count[%0d]", i), int'(if1.count), seq_w[i]);
      chk($sformatf("dw_evt[%0d]", i),   int'(if1.evt), (i == 4) ? 1 : 0);
    end
    if1.en = 0;
`endif

    // Wrap-up STEP=2, lo=2, hi=5 from reset
    if2.lo = 2; if2.hi = 5; if2.mode = MODE_UP; if2.en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("up2_count[%0d]", i), int'(if2.count), seq_b[i]);
      chk($sformatf("up2_evt[%0d]", i),   int'(if2.evt), evt_b[i]);
    end
    if2.en = 0;

`ifndef GIDC_DWELL_EN
    // Ping-pong STEP=3 over 0..7
    if3.lo = 0; if3.hi = 7; if3.mode = MODE_PINGPONG; if3.en = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("pp3_count[%0d]", i), int'(if3.count), seq_c[i]);
      chk($sformatf("pp3_evt[%0d]", i),   int'(if3.evt), evt_c[i]);
    end
    if3.en = 0;
`endif

    // Wrap-down STEP=3, lo=1, hi=7 after load 7
    if3.lo = 1; if3.hi = 7; if3.mode = MODE_DOWN; if3.load = 1; if3.load_val = 7;
    tick();
    chk("dn3_load", int'(if3.count), 7);
    chk("dn3_load_evt", int'(if3.evt), 0);
    if3.load = 0; if3.en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("dn3_count[%0d]", i), int'(if3.count), seq_d[i]);
      chk($sformatf("dn3_evt[%0d]", i),   int'(if3.evt), (i == 2) ? 1 : 0);
    end
    chk("dn3_dir", int'(if3.dir), 0);
    if3.en = 0;

    // Load wins over enable
    if1.mode = MODE_UP; if1.lo = 0; if1.hi = 7; if1.en = 1; if1.load = 1; if1.load_val = 5;
    tick();
    chk("ld_count", int'(if1.count), 5);
    chk("ld_evt",   int'(if1.evt),   0);
    if1.load = 0;

    // lo > hi: cfg_err, count holds while enabled
    if1.lo = 6; if1.hi = 2;
    #1;
    chk("cfg_err_on", int'(if1.cfg_err), 1);
    tick();
    chk("cfg_hold", int'(if1.count), 5);
    chk("cfg_evt",  int'(if1.evt),   0);
    if1.en = 0;

    // WIDTH=4 wrap at 15 without overflow
    if4.lo = 3; if4.hi = 15; if4.mode = MODE_UP; if4.load = 1; if4.load_val = 14;
    tick();
    chk("w4_load", int'(if4.count), 14);
    if4.load = 0; if4.en = 1;
    tick();
    chk("w4_15", int'(if4.count), 15);
    chk("w4_at_hi", int'(if4.at_hi), 1);
    tick();
    chk("w4_wrap", int'(if4.count), 3);
    chk("w4_wrap_evt", int'(if4.evt), 1);
    chk("w4_at_lo", int'(if4.at_lo), 1);
    if4.en = 0;

    // lo == hi: recover to 4 (no evt), then evt every enabled cycle
    if1.lo = 4; if1.hi = 4; if1.mode = MODE_UP; if1.en = 1;
    #1;
    chk("eq_cfg_err", int'(if1.cfg_err), 0);
    tick();
    chk("eq_rec_count", int'(if1.count), 4);
    chk("eq_rec_evt",   int'(if1.evt),   0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("eq_count[%0d]", i), int'(if1.count), 4);
      chk($sformatf("eq_evt[%0d]", i),   int'(if1.evt),   1);
    end
    chk("eq_at_lo", int'(if1.at_lo), 1);
`ifndef GIDC_DWELL_EN
    if1.mode = MODE_PINGPONG;
    tick();
    chk("eq_pp_dir0", int'(if1.dir), 0);
    chk("eq_pp_evt0", int'(if1.evt), 1);
    tick();
    chk("eq_pp_dir1", int'(if1.dir), 1);
    chk("eq_pp_evt1", int'(if1.evt), 1);
`endif
    if1.en = 0;

    // Reset beats load and enable
    if1.lo = 0; if1.hi = 7; if1.mode = MODE_DOWN; if1.en = 1; if1.load = 1; if1.load_val = 5;
    rst = 1'b1;
    tick();
    chk("rst_ld_count", int'(if1.count), 0);
    chk("rst_ld_dir",   int'(if1.dir),   1);
    chk("rst_ld_evt",   int'(if1.evt),   0);
    rst = 1'b0; if1.load = 0; if1.en = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
